// File: rtl/biquad_cascade.sv
// biquad_cascade: cascade of direct-form-I biquad sections sharing one multiplier.
// Each sample runs 5 MAC cycles plus 1 SCALE cycle per section, then waits in OUT
// until the downstream handshake. Coefficients are programmable per section.
// Optional feature macro: BIQUAD_SATURATE_EN. When it is defined, results clamp to the
// DATA_W range and the sticky saturated flag is set. Otherwise results wrap and
// saturated is tied to 0.
module biquad_cascade #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned COEF_W    = 16,
  parameter int unsigned COEF_FRAC = 14,
  parameter int unsigned SECTIONS  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              cfg_write,
  input  logic [7:0]        cfg_address,
  input  logic [31:0]       cfg_writedata,
  output logic              cfg_waitrequest,
  input  logic              clear_state,
  output logic              busy,
  output logic              saturated
);

  localparam int unsigned ACC_W    = DATA_W + COEF_W + 3;
  localparam int unsigned PROD_W   = DATA_W + COEF_W;
  localparam int unsigned SEC_W    = (SECTIONS > 1) ? $clog2(SECTIONS) : 1;
  localparam int unsigned NUM_COEF = 5;

  typedef enum logic [1:0] {StIdle, StMac, StScale, StOut} state_e;

  state_e                   state_q;
  logic [SEC_W-1:0]         sec_q;
  logic [2:0]               k_q;
  logic signed [DATA_W-1:0] x_cur_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic                     out_valid_q;
  logic [DATA_W-1:0]        out_data_q;

  // Coefficient order per section: b0, b1, b2, a1, a2.
  logic signed [COEF_W-1:0] coef_q [SECTIONS][NUM_COEF];
  logic signed [DATA_W-1:0] x1_q [SECTIONS];
  logic signed [DATA_W-1:0] x2_q [SECTIONS];
  logic signed [DATA_W-1:0] y1_q [SECTIONS];
  logic signed [DATA_W-1:0] y2_q [SECTIONS];

  // Handshake and status outputs decode straight from the state register.
  assign in_ready        = (state_q == StIdle);
  assign busy            = (state_q != StIdle);
  assign cfg_waitrequest = (state_q != StIdle) | clear_state;
  assign out_valid       = out_valid_q;
  assign out_data        = out_data_q;

  // Configuration decode; writes outside the populated range are swallowed.
  logic [4:0] cfg_sec;
  logic [2:0] cfg_idx;
  logic       cfg_hit;
  logic       cfg_accept;
  logic       unused_cfg;

  assign cfg_sec    = cfg_address[7:3];
  assign cfg_idx    = cfg_address[2:0];
  assign cfg_hit    = (32'(cfg_sec) < SECTIONS) && (cfg_idx < 3'd5);
  assign cfg_accept = cfg_write && !cfg_waitrequest && cfg_hit;
  assign unused_cfg = ^cfg_writedata[31:COEF_W];

  // Coefficient store, reset to a unity pass-through filter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SECTIONS; i++) begin
        for (int j = 0; j < NUM_COEF; j++) begin
          coef_q[i][j] <= (j == 0) ? COEF_W'(1 << COEF_FRAC) : '0;
        end
      end
    end else if (cfg_accept) begin
      coef_q[cfg_sec[SEC_W-1:0]][cfg_idx] <= cfg_writedata[COEF_W-1:0];
    end
  end

  // Shared multiplier: select the operand pair for tap k of the current section.
  logic signed [DATA_W-1:0] mul_a;
  logic signed [COEF_W-1:0] mul_b;
  logic                     mul_sub;
  logic signed [PROD_W-1:0] mul_a_ext;
  logic signed [PROD_W-1:0] mul_b_ext;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_base;
  logic signed [ACC_W-1:0]  acc_next;

  always_comb begin
    mul_a   = x_cur_q;
    mul_b   = coef_q[sec_q][0];
    mul_sub = 1'b0;
    case (k_q)
      3'd1: begin
        mul_a = x1_q[sec_q];
        mul_b = coef_q[sec_q][1];
      end
      3'd2: begin
        mul_a = x2_q[sec_q];
        mul_b = coef_q[sec_q][2];
      end
      3'd3: begin
        mul_a   = y1_q[sec_q];
        mul_b   = coef_q[sec_q][3];
        mul_sub = 1'b1;
      end
      3'd4: begin
        mul_a   = y2_q[sec_q];
        mul_b   = coef_q[sec_q][4];
        mul_sub = 1'b1;
      end
      default: ;
    endcase
    // Sign-extend both operands to the full product width before multiplying.
    mul_a_ext = PROD_W'(mul_a);
    mul_b_ext = PROD_W'(mul_b);
    prod      = mul_a_ext * mul_b_ext;
    acc_base  = (k_q == 3'd0) ? '0 : acc_q;
    acc_next  = mul_sub ? (acc_base - ACC_W'(prod)) : (acc_base + ACC_W'(prod));
  end

  // Rescale the accumulator to a sample, clamping or wrapping on overflow.
  logic signed [DATA_W-1:0] y_val;
`ifdef BIQUAD_SATURATE_EN
  localparam logic [DATA_W-1:0] SatMax = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SatMin = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [ACC_W-1:0] shifted;
  logic                    ovf;
  logic                    sat_q;

  always_comb begin
    shifted = acc_q >>> COEF_FRAC;
    // In range only when every bit above the DATA_W sign bit matches it.
    ovf     = !((&shifted[ACC_W-1:DATA_W-1]) || !(|shifted[ACC_W-1:DATA_W-1]));
    y_val   = ovf ? (shifted[ACC_W-1] ? SatMin : SatMax) : shifted[DATA_W-1:0];
  end

  // Sticky overflow flag; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_q <= 1'b0;
    end else if (!clear_state && (state_q == StScale) && ovf) begin
      sat_q <= 1'b1;
    end
  end

  assign saturated = sat_q;
`else
  always_comb begin
    y_val = DATA_W'(acc_q >>> COEF_FRAC);
  end

  assign saturated = 1'b0;
`endif

  // Sequencer: accept, MAC five taps, scale and update delay lines, per section.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      sec_q       <= '0;
      k_q         <= '0;
      x_cur_q     <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int i = 0; i < SECTIONS; i++) begin
        x1_q[i] <= '0;
        x2_q[i] <= '0;
        y1_q[i] <= '0;
        y2_q[i] <= '0;
      end
    end else if (clear_state) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      for (int i = 0; i < SECTIONS; i++) begin
        x1_q[i] <= '0;
        x2_q[i] <= '0;
        y1_q[i] <= '0;
        y2_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            x_cur_q <= in_data;
            sec_q   <= '0;
            k_q     <= '0;
            state_q <= StMac;
          end
        end
        StMac: begin
          acc_q <= acc_next;
          if (k_q == 3'd4) begin
            state_q <= StScale;
          end else begin
            k_q <= k_q + 3'd1;
          end
        end
        StScale: begin
          x2_q[sec_q] <= x1_q[sec_q];
          x1_q[sec_q] <= x_cur_q;
          y2_q[sec_q] <= y1_q[sec_q];
          y1_q[sec_q] <= y_val;
          if (sec_q == SEC_W'(SECTIONS - 1)) begin
            out_data_q  <= y_val;
            out_valid_q <= 1'b1;
            state_q     <= StOut;
          end else begin
            x_cur_q <= y_val;
            sec_q   <= sec_q + SEC_W'(1);
            k_q     <= '0;
            state_q <= StMac;
          end
        end
        StOut: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_biquad_cascade.sv
// Bench for biquad_cascade: directed cases with literal expectations plus randomized
// traffic, all checked against a sample-level cascade model kept in the bench.
module tb_biquad_cascade;

  localparam int  DATA_W    = 32;
  localparam int  COEF_W    = 16;
  localparam int  COEF_FRAC = 14;
  localparam int  SECTIONS  = 2;
  localparam int  LAT       = 6 * SECTIONS;
  localparam longint MAXV   = 64'sd2147483647;
  localparam longint MINV   = -64'sd2147483648;
`ifdef BIQUAD_SATURATE_EN
  localparam longint SAT_OUT = 64'sd2147483647;
  localparam longint EXP_SAT = 1;
`else
  localparam longint SAT_OUT = -64'sd536985600;
  localparam longint EXP_SAT = 0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              cfg_write = 1'b0;
  logic [7:0]        cfg_address = '0;
  logic [31:0]       cfg_writedata = '0;
  logic              cfg_waitrequest;
  logic              clear_state = 1'b0;
  logic              busy;
  logic              saturated;

  bit rand_ready = 1'b0;
  bit man_ready  = 1'b1;
  bit rnd_bit    = 1'b0;
  assign out_ready = rand_ready ? rnd_bit : man_ready;

  always #5 clk = ~clk;

  biquad_cascade #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .COEF_FRAC(COEF_FRAC), .SECTIONS(SECTIONS)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_write(cfg_write), .cfg_address(cfg_address), .cfg_writedata(cfg_writedata),
    .cfg_waitrequest(cfg_waitrequest), .clear_state(clear_state),
    .busy(busy), .saturated(saturated)
  );

  // ---------------- reference model: whole cascade evaluated per sample ----------------
  longint m_coef [SECTIONS][5];
  longint m_x1 [SECTIONS];
  longint m_x2 [SECTIONS];
  longint m_y1 [SECTIONS];
  longint m_y2 [SECTIONS];
  bit     m_sat;

  typedef struct {
    longint y;
    bit     sat;
  } exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  function automatic void model_clear();
    for (int s = 0; s < SECTIONS; s++) begin
      m_x1[s] = 0; m_x2[s] = 0; m_y1[s] = 0; m_y2[s] = 0;
    end
  endfunction

  function automatic void model_power_on();
    model_clear();
    for (int s = 0; s < SECTIONS; s++) begin
      m_coef[s][0] = 64'sd1 <<< COEF_FRAC;
      for (int j = 1; j < 5; j++) m_coef[s][j] = 0;
    end
    m_sat = 1'b0;
  endfunction

  function automatic void model_step(input longint x_in);
    longint x, acc, sh, y;
    exp_t e;
    x = x_in;
    for (int s = 0; s < SECTIONS; s++) begin
      acc = m_coef[s][0] * x + m_coef[s][1] * m_x1[s] + m_coef[s][2] * m_x2[s]
            - m_coef[s][3] * m_y1[s] - m_coef[s][4] * m_y2[s];
      sh = acc >>> COEF_FRAC;
`ifdef BIQUAD_SATURATE_EN
      if (sh > MAXV) begin
        y = MAXV; m_sat = 1'b1;
      end else if (sh < MINV) begin
        y = MINV; m_sat = 1'b1;
      end else begin
        y = sh;
      end
`else
      y = longint'(int'(sh));
`endif
      m_x2[s] = m_x1[s]; m_x1[s] = x;
      m_y2[s] = m_y1[s]; m_y1[s] = y;
      x = y;
    end
    e.y = x;
    e.sat = m_sat;
    exp_q.push_back(e);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- compare process: every cycle the output is valid ----------------
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", longint'(out_valid), 0);
      end else begin
        check("out_data", longint'($signed(out_data)), exp_q[0].y);
        check("saturated", longint'(saturated), longint'(exp_q[0].sat));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Random backpressure source, changed just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1 rnd_bit = ($urandom_range(0, 1) == 1);
    end
  end

  // ---------------- stimulus helpers (all return at posedge + 1) ----------------
  task automatic accept_sample(input longint data);
    int n = 0;
    in_data  = data[DATA_W-1:0];
    in_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 400) begin
        check("in_ready_timeout", longint'(in_ready), 1);
        break;
      end
    end
    @(posedge clk);
    model_step(data);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_output(input bit use_lit, input longint lit);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < LAT + 20) begin
      @(posedge clk);
      n++;
      #1;
      if (out_valid) seen = 1'b1;
      else check("in_ready_while_busy", longint'(in_ready), 0);
    end
    check("latency", seen ? longint'(n) : -1, LAT);
    if (seen && use_lit) check("literal_out", longint'($signed(out_data)), lit);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("idle_timeout", longint'(busy), 0);
  endtask

  task automatic sample(input longint data, input bit use_lit, input longint lit);
    accept_sample(data);
    wait_output(use_lit, lit);
    wait_idle();
  endtask

  task automatic cfg_wr(input int sec, input int idx, input int val);
    int n = 0;
    logic signed [COEF_W-1:0] c;
    cfg_address   = {sec[4:0], idx[2:0]};
    cfg_writedata = val;
    cfg_write     = 1'b1;
    while (1) begin
      @(negedge clk);
      if (!cfg_waitrequest) break;
      n++;
      if (n > 400) begin
        check("cfg_wait_timeout", longint'(cfg_waitrequest), 0);
        break;
      end
    end
    @(posedge clk);
    if (sec < SECTIONS && idx < 5) begin
      c = val[COEF_W-1:0];
      m_coef[sec][idx] = longint'(c);
    end
    #1 cfg_write = 1'b0;
  endtask

  task automatic clear_pulse();
    clear_state = 1'b1;
    @(posedge clk);
    #1 clear_state = 1'b0;
    model_clear();
    exp_q.delete();
    check("clear_busy", longint'(busy), 0);
    check("clear_out_valid", longint'(out_valid), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    longint d;
    model_power_on();
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", longint'(in_ready), 1);
    check("rst_busy", longint'(busy), 0);
    check("rst_waitreq", longint'(cfg_waitrequest), 0);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_data", longint'(out_data), 0);
    check("rst_saturated", longint'(saturated), 0);
    reset = 1'b0;

    // Pass-through defaults.
    sample(1000, 1'b1, 1000);
    sample(-5, 1'b1, -5);

    // Half gain in one then both sections.
    cfg_wr(0, 0, 8192);
    sample(1000, 1'b1, 500);
    cfg_wr(1, 0, 8192);
    sample(1000, 1'b1, 250);

    // Output stall with a config write pending; the write lands only after the handshake.
    man_ready = 1'b0;
    accept_sample(1000);
    wait_output(1'b1, 250);
    cfg_address   = {5'd1, 3'd0};
    cfg_writedata = 32'd16384;
    cfg_write     = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("waitreq_stall", longint'(cfg_waitrequest), 1);
      check("out_valid_hold", longint'(out_valid), 1);
    end
    @(posedge clk);
    #1 man_ready = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (!cfg_waitrequest) break;
      n++;
      if (n > 50) begin
        check("stall_release_timeout", longint'(cfg_waitrequest), 0);
        break;
      end
    end
    @(posedge clk);
    m_coef[1][0] = 16384;
    #1 cfg_write = 1'b0;
    check("idle_after_release", longint'(busy), 0);

    // Writes outside the populated range must not alter anything.
    cfg_wr(2, 0, 100);
    cfg_wr(0, 6, 100);
    sample(1000, 1'b1, 500);

    // First-order recursion: y = x + y1/2.
    cfg_wr(0, 0, 16384);
    cfg_wr(0, 3, -8192);
    clear_pulse();
    sample(1024, 1'b1, 1024);
    sample(0, 1'b1, 512);
    sample(0, 1'b1, 256);
    sample(0, 1'b1, 128);

    // Abort during section 1 MAC, then restart from zero state.
    clear_pulse();
    accept_sample(1024);
    repeat (7) @(posedge clk);
    #1;
    check("busy_before_abort", longint'(busy), 1);
    clear_state = 1'b1;
    @(posedge clk);
    #1 clear_state = 1'b0;
    model_clear();
    exp_q.delete();
    check("abort_busy", longint'(busy), 0);
    check("abort_out_valid", longint'(out_valid), 0);
    repeat (LAT + 4) begin
      @(negedge clk);
      check("no_out_after_abort", longint'(out_valid), 0);
    end
    @(posedge clk);
    #1;
    sample(1024, 1'b1, 1024);
    sample(0, 1'b1, 512);
    sample(0, 1'b1, 256);

    // Overflow: clamp or wrap depending on build.
    clear_pulse();
    cfg_wr(0, 3, 0);
    cfg_wr(0, 0, 32767);
    sample(64'sh7000_0000, 1'b1, SAT_OUT);
    check("saturated_flag", longint'(saturated), EXP_SAT);

    // Randomized traffic with backpressure, config writes and occasional clears.
    rand_ready = 1'b1;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        cfg_wr(int'($urandom_range(0, 2)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 32767)) - 16384);
      end
      if ($urandom_range(0, 9) == 0) clear_pulse();
      d = longint'($signed($urandom()));
      if ($urandom_range(0, 1) == 0) d = d >>> 12;
      sample(d, 1'b0, 0);
    end
    rand_ready = 1'b0;
    man_ready  = 1'b1;
    @(posedge clk);
    #1;

    // Reset mid-sample returns everything to power-on values at once.
    accept_sample(777);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_busy", longint'(busy), 0);
    check("midrst_in_ready", longint'(in_ready), 1);
    check("midrst_out_valid", longint'(out_valid), 0);
    check("midrst_saturated", longint'(saturated), 0);
    check("midrst_waitreq", longint'(cfg_waitrequest), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    model_power_on();
    exp_q.delete();
    sample(1000, 1'b1, 1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule
